vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port 16-bit video RAM between display refresh and CPU. Using the pixel counters from the 25 MHz sync generator, it reserves one RAM slot per 16-pixel group to fetch the next display word and pulses the shifter's load input. All remaining slots serve a one-outstanding CPU read/write handshake. An optional vertical scroll register offsets the displayed row.

## Interface
- No parameters; geometry is fixed: 512×256 display, 32 words per row, 13-bit word address.
- clk25  in  1  pixel clock, 25 MHz
- res_n  in  1  asynchronous active-low reset
- x  in  10  current pixel X, 0..703, wraps 703→0
- y  in  10  current line Y, 0..625, increments when x wraps
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_be  in  2  write byte enables
- cpu_addr  in  13  word address
- cpu_wdata  in  16  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid when cpu_ack=1
- ram_addr  out  13  registered RAM address
- ram_we  out  1  registered write strobe
- ram_be  out  2  registered byte enables
- ram_wdata  out  16  registered write data
- ram_rdata  in  16  synchronous RAM read data, 1-cycle latency
- vid_data  out  16  word for the shifter
- vid_load  out  1  shifter load strobe
- scroll_we  in  1  scroll register write strobe
- scroll_in  in  8  scroll value

## Operation
- Grant cycle: x[3:0]==11. The video fetch is active if either condition holds:
  - y<512 and x<496: fetch row y[8:1], column x[8:4]+1.
  - x==699: fetch column 0 of the next line, ny = (y==625 ? 0 : y+1). Active only if ny<512; row is ny[8:1].
- Displayed row = row + scroll (mod 256) with SCROLL_EN. Fetch address = {row[7:0], col[4:0]}.
- Active grant: ram_addr is driven with the fetch address during x≡12, ram_we=0. ram_rdata is captured into vid_data at the end of x≡13.
- Inactive grant: vid_data is loaded with 0 at the end of x≡13. The slot is free for the CPU.
- vid_load is registered high exactly during cycles with x[3:0]==15.
- CPU FSM states: IDLE → ISSUE → WAIT → ACK → IDLE.
  - IDLE→ISSUE when cpu_req=1 and the current cycle is not an active grant.
  - In ISSUE, ram_* carry the CPU request; ram_we=cpu_we and ram_be=cpu_be for one cycle.
  - In WAIT, ram_rdata is captured into cpu_rdata. Writes also update cpu_rdata; the value is don't-care.
  - In ACK, cpu_ack=1. Writes and reads are acked identically.
  - From ACK, IDLE re-evaluates on the next cycle. A request still high is a new access.
- The video slot always wins. CPU waits at most 1 extra cycle.
- ram_we is never asserted in a video slot.
- Reset values: every output 0; FSM in IDLE; scroll register 0.
- Reset mid-access: aborts immediately, no ack issued, and the CPU re-requests.

## Timing
- CPU latency: req sampled in IDLE at cycle n, not blocked → ack at n+3. Blocked by grant → ack at n+4.
- Throughput: one CPU access per 4 cycles.
- Video path: grant at x≡11, address at x≡12, RAM data at x≡13, vid_data stable from x≡14 through the next x≡13, vid_load at x≡15.
- The shifter therefore loads the word for pixels x+1..x+16.
- Word 0 of each line is fetched at x=699 and loaded at x=703.
- Scroll register: written on any clk25 edge with scroll_we=1. The displayed offset is the copy latched when x==0 and y==0. Mid-frame writes take effect at the next frame.

## Configuration
- VRAM_SCROLL_EN defined:
  - Scroll register and frame latch are implemented.
  - Row = fetch row + latched scroll, mod 256 (fetches wrap around the 16 KB screen).
- Undefined:
  - Row = fetch row.
  - scroll_we and scroll_in are ignored; no scroll flops are built.

## Test plan
- Video addresses at y=10:
  - x=11 grant → ram_addr=0x0A1 at x=12.
  - x=699 → ram_addr=0x0A0 (next line y=11, row 5).
  - RAM preloaded with addr-as-data: vid_data=0x0A1 during x=14..29, vid_load high at x=15, 31, 47….
- Inactive regions: x=507 (x[3:0]=11, x≥496) and y=600 → no video address driven, vid_data=0. A CPU req at x=507 is issued at x=508.
- CPU collision: cpu_req read of 0x1234 rising at x=27 (x≡11, active) → ISSUE at x=29, cpu_ack at x=31, cpu_rdata=0x1234; vid_data unaffected.
- CPU write cpu_addr=0x0005, be=2'b10, wdata=0xBEEF at x=600 → ram_we=1, ram_be=2'b10 for exactly one cycle; ack 3 cycles after req; read back returns 0xBExx.
- Scroll (VRAM_SCROLL_EN): write 8'd250 mid-frame → unchanged until the frame latch. Next frame, y=20 grant at x=11 → ram_addr={8'd4, 5'd1} (10+250 wraps).
- Reset: assert res_n low during CPU WAIT → all outputs 0 asynchronously, no ack. After release, the first req completes with normal latency.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the CPU access handshake and the single-port video RAM bus that
// vram_arbiter sits between.
//   slave  modport : the arbiter side (accepts CPU requests, drives the RAM)
//   master modport : the environment side (issues CPU requests, models RAM)
// Signals:
//   cpu_req/cpu_we/cpu_be/cpu_addr/cpu_wdata : CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata                        : one-cycle completion + read data
//   ram_addr/ram_we/ram_be/ram_wdata         : registered RAM command
//   ram_rdata                                : synchronous RAM read data
// -----------------------------------------------------------------------------
interface vram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  logic [12:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_ack, cpu_rdata, ram_addr, ram_we, ram_be, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_ack, cpu_rdata, ram_addr, ram_we, ram_be, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares the single-port 16-bit video RAM between display refresh and the CPU.
// One slot per 16-pixel group (x[3:0]==11) is reserved for fetching the next
// display word; all other cycles serve a one-outstanding CPU handshake.
//
// Ports:
//   clk25            pixel clock
//   res_n            asynchronous active-low reset
//   x, y             pixel/line counters from the sync generator
//   bus (slave)      CPU handshake + RAM command/read-data (vram_arbiter_if)
//   vid_data         word for the pixel shifter
//   vid_load         shifter load strobe, high during x[3:0]==15
//   scroll_we/in     vertical scroll register write port
//
// Build option: define VRAM_SCROLL_EN to build the vertical scroll register
// and its frame latch. Without it the scroll inputs are ignored.
// -----------------------------------------------------------------------------
module vram_arbiter (
  input  logic          clk25,
  input  logic          res_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  vram_arbiter_if.slave bus,
  output logic [15:0]   vid_data,
  output logic          vid_load,
  input  logic          scroll_we,
  input  logic [7:0]    scroll_in
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } cpuState_t;

  cpuState_t   r_state;
  cpuState_t   w_nextState;
  logic        w_issue;
  logic        w_cpuAck;

  logic        w_isGrant;
  logic        w_lineFetch;
  logic        w_wrapFetch;
  logic        w_grantActive;
  logic [9:0]  w_nextY;
  logic [7:0]  w_fetchRow;
  logic [4:0]  w_fetchCol;
  logic [7:0]  w_dispRow;
  logic [12:0] w_fetchAddr;

  logic        r_fetchPend;
  logic [15:0] r_vidData;
  logic        r_vidLoad;
  logic [12:0] r_ramAddr;
  logic        r_ramWe;
  logic [1:0]  r_ramBe;
  logic [15:0] r_ramWdata;
  logic [15:0] r_cpuRdata;

  // Grant slot decode. The fetch issued at x==11 of a group is for the word
  // displayed in the following group, hence column +1. The last grant of a
  // line (x==699) prefetches column 0 of the next line.
  assign w_isGrant     = (x[3:0] == 4'd11);
  assign w_lineFetch   = (y < 10'd512) && (x < 10'd496);
  assign w_nextY       = (y == 10'd625) ? 10'd0 : y + 10'd1;
  assign w_wrapFetch   = (x == 10'd699) && (w_nextY < 10'd512);
  assign w_grantActive = w_isGrant && (w_lineFetch || w_wrapFetch);
  assign w_fetchRow    = w_wrapFetch ? w_nextY[8:1] : y[8:1];
  assign w_fetchCol    = w_wrapFetch ? 5'd0 : x[8:4] + 5'd1;

`ifdef VRAM_SCROLL_EN
  logic [7:0] r_scrollReg;
  logic [7:0] r_scrollLatched;

  // The written value only becomes visible at the top-left pixel so a frame
  // never shows two different scroll offsets.
  always_ff @(posedge clk25 or negedge res_n) begin
    if (!res_n) begin
      r_scrollReg     <= 8'd0;
      r_scrollLatched <= 8'd0;
    end else begin
      if (scroll_we)
        r_scrollReg <= scroll_in;
      if ((x == 10'd0) && (y == 10'd0))
        r_scrollLatched <= r_scrollReg;
    end
  end

  // 8-bit add wraps around the 256-row screen.
  assign w_dispRow = w_fetchRow + r_scrollLatched;
`else
  logic w_unusedScroll;
  assign w_unusedScroll = scroll_we ^ (^scroll_in);
  assign w_dispRow      = w_fetchRow;
`endif

  assign w_fetchAddr = {w_dispRow, w_fetchCol};

  // CPU handshake state register.
  always_ff @(posedge clk25 or negedge res_n) begin
    if (!res_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  // A request is only accepted outside an active grant, so the video slot
  // always wins and the CPU is delayed by at most one cycle.
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_cpuAck    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req && !w_grantActive) begin
          w_issue     = 1'b1;
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: w_nextState = ST_WAIT;
      ST_WAIT:  w_nextState = ST_ACK;
      ST_ACK: begin
        w_cpuAck    = 1'b1;
        w_nextState = ST_IDLE;
      end
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // RAM command register. The video fetch is always a read; write strobe and
  // byte enables are only non-zero during the single CPU issue cycle. The
  // address and write data hold their last value when the port is idle.
  always_ff @(posedge clk25 or negedge res_n) begin
    if (!res_n) begin
      r_ramAddr  <= 13'd0;
      r_ramWe    <= 1'b0;
      r_ramBe    <= 2'b00;
      r_ramWdata <= 16'd0;
    end else if (w_grantActive) begin
      r_ramAddr  <= w_fetchAddr;
      r_ramWe    <= 1'b0;
      r_ramBe    <= 2'b00;
    end else if (w_issue) begin
      r_ramAddr  <= bus.cpu_addr;
      r_ramWe    <= bus.cpu_we;
      r_ramBe    <= bus.cpu_be;
      r_ramWdata <= bus.cpu_wdata;
    end else begin
      r_ramWe    <= 1'b0;
      r_ramBe    <= 2'b00;
    end
  end

  // Read data for the CPU arrives in WAIT; writes capture harmless data.
  always_ff @(posedge clk25 or negedge res_n) begin
    if (!res_n)
      r_cpuRdata <= 16'd0;
    else if (r_state == ST_WAIT)
      r_cpuRdata <= bus.ram_rdata;
  end

  // Video pipeline: grant at x==11, address at 12, data at 13, word held
  // from 14 until the next 13, load strobe at 15. An idle slot blanks the word.
  always_ff @(posedge clk25 or negedge res_n) begin
    if (!res_n) begin
      r_fetchPend <= 1'b0;
      r_vidData   <= 16'd0;
      r_vidLoad   <= 1'b0;
    end else begin
      if (w_isGrant)
        r_fetchPend <= w_grantActive;
      if (x[3:0] == 4'd13)
        r_vidData <= r_fetchPend ? bus.ram_rdata : 16'd0;
      r_vidLoad <= (x[3:0] == 4'd14);
    end
  end

  assign bus.ram_addr  = r_ramAddr;
  assign bus.ram_we    = r_ramWe;
  assign bus.ram_be    = r_ramBe;
  assign bus.ram_wdata = r_ramWdata;
  assign bus.cpu_ack   = w_cpuAck;
  assign bus.cpu_rdata = r_cpuRdata;
  assign vid_data      = r_vidData;
  assign vid_load      = r_vidLoad;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter. The bench plays the sync generator (x/y
// counters, which it may jump to any position), the CPU and a synchronous
// 8K x 16 RAM preloaded with each word's own address as data.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clk25;
  logic        res_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [15:0] vid_data;
  logic        vid_load;
  logic        scroll_we;
  logic [7:0]  scroll_in;

  int checkCount;
  int errorCount;

  logic [15:0] mem [0:8191];

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clk25     (clk25),
    .res_n     (res_n),
    .x         (x),
    .y         (y),
    .bus       (bus.slave),
    .vid_data  (vid_data),
    .vid_load  (vid_load),
    .scroll_we (scroll_we),
    .scroll_in (scroll_in)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  // Synchronous single-port RAM, read-before-write, one cycle read latency.
  always @(posedge clk25) begin
    if (bus.ram_we) begin
      if (bus.ram_be[1]) mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      if (bus.ram_be[0]) mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ram"}, {16'd0, bus.ram_addr, bus.ram_we, bus.ram_be}, 32'd0);
    checkOutput({tag, "_wdata"}, {16'd0, bus.ram_wdata}, 32'd0);
    checkOutput({tag, "_cpu"}, {15'd0, bus.cpu_ack, bus.cpu_rdata}, 32'd0);
    checkOutput({tag, "_vid"}, {15'd0, vid_load, vid_data}, 32'd0);
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [1:0] be,
                               input logic [12:0] addr, input logic [15:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_be    = be;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic setPos(input int xv, input int yv);
    x = 10'(xv);
    y = 10'(yv);
  endtask

  // One pixel clock: cross the active edge, then advance the counters 1 unit
  // later so the new cycle's inputs settle away from the edge.
  task automatic nextPix();
    @(posedge clk25);
    #1;
    if (x == 10'd703) begin
      x = 10'd0;
      y = (y == 10'd625) ? 10'd0 : y + 10'd1;
    end else begin
      x = x + 10'd1;
    end
  endtask

  task automatic advanceTo(input int target);
    int n;
    n = 0;
    while ((x != 10'(target)) && (n < 1500)) begin
      nextPix();
      n++;
    end
    if (x != 10'(target)) begin
      errorCount++;
      $display("[TB] FAIL advance: x stuck at %0d, wanted %0d", x, target);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    res_n     = 1'b0;
    scroll_we = 1'b0;
    scroll_in = 8'd0;
    setPos(0, 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 13'd0, 16'd0);
    #1;
    checkAllZero("reset");

    @(posedge clk25);
    #1;
    res_n = 1'b1;
    setPos(0, 10);

    // Line y=10: row 5, fetch at x=11 for column 1
    advanceTo(12);
    checkOutput("vaddr_x12", 32'(bus.ram_addr), 32'h0A1);
    checkOutput("vwe_x12", 32'(bus.ram_we), 32'd0);
    advanceTo(14);
    checkOutput("vdata_x14", 32'(vid_data), 32'h0A1);
    advanceTo(15);
    checkOutput("vload_x15", 32'(vid_load), 32'd1);
    advanceTo(16);
    checkOutput("vload_x16", 32'(vid_load), 32'd0);

    // CPU read collides with the x=27 grant
    advanceTo(27);
    applyStimulus(1'b1, 1'b0, 2'b00, 13'h1234, 16'd0);
    nextPix();
    checkOutput("col_addr_x28", 32'(bus.ram_addr), 32'h0A2);
    nextPix();
    checkOutput("col_addr_x29", 32'(bus.ram_addr), 32'h1234);
    checkOutput("vdata_x29", 32'(vid_data), 32'h0A1);
    nextPix();
    checkOutput("col_ack_x30", 32'(bus.cpu_ack), 32'd0);
    checkOutput("col_vdata_x30", 32'(vid_data), 32'h0A2);
    nextPix();
    checkOutput("col_ack_x31", 32'(bus.cpu_ack), 32'd1);
    checkOutput("col_rdata_x31", 32'(bus.cpu_rdata), 32'h1234);
    checkOutput("vload_x31", 32'(vid_load), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 13'd0, 16'd0);

    // Inactive grant at x=507: CPU gets the slot, word blanks
    advanceTo(507);
    applyStimulus(1'b1, 1'b0, 2'b00, 13'h0ABC, 16'd0);
    nextPix();
    checkOutput("idle_addr_x508", 32'(bus.ram_addr), 32'h0ABC);
    nextPix();
    checkOutput("vdata_x509", 32'(vid_data), 32'h0BF);
    nextPix();
    checkOutput("vdata_x510", 32'(vid_data), 32'd0);
    checkOutput("idle_ack_x510", 32'(bus.cpu_ack), 32'd1);
    checkOutput("idle_rdata_x510", 32'(bus.cpu_rdata), 32'h0ABC);
    applyStimulus(1'b0, 1'b0, 2'b00, 13'd0, 16'd0);

    // End-of-line prefetch of line 11 (row 5) column 0
    advanceTo(700);
    checkOutput("wrap_addr_x700", 32'(bus.ram_addr), 32'h0A0);
    advanceTo(702);
    checkOutput("wrap_vdata_x702", 32'(vid_data), 32'h0A0);
    nextPix();
    checkOutput("wrap_vload_x703", 32'(vid_load), 32'd1);
    nextPix();
    checkOutput("wrap_y", 32'(y), 32'd11);

    // CPU byte write to word 5, then read it back
    advanceTo(600);
    applyStimulus(1'b1, 1'b1, 2'b10, 13'h0005, 16'hBEEF);
    nextPix();
    checkOutput("wr_cmd_x601", {bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata},
                {1'b1, 2'b10, 13'h0005, 16'hBEEF});
    nextPix();
    checkOutput("wr_strobe_x602", {30'd0, bus.ram_we, bus.cpu_ack}, 32'd0);
    checkOutput("wr_be_x602", 32'(bus.ram_be), 32'd0);
    nextPix();
    checkOutput("wr_ack_x603", 32'(bus.cpu_ack), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 13'd0, 16'd0);
    nextPix();
    applyStimulus(1'b1, 1'b0, 2'b00, 13'h0005, 16'd0);
    nextPix();
    nextPix();
    nextPix();
    checkOutput("rd_ack_x607", 32'(bus.cpu_ack), 32'd1);
    checkOutput("rd_rdata_x607", 32'(bus.cpu_rdata), 32'hBE05);
    applyStimulus(1'b0, 1'b0, 2'b00, 13'd0, 16'd0);

    // Blanking line y=600: no fetch, port keeps the last CPU address
    setPos(0, 600);
    advanceTo(12);
    checkOutput("blank_addr_x12", {15'd0, bus.ram_we, 3'd0, bus.ram_addr}, 32'h0005);
    advanceTo(14);
    checkOutput("blank_vdata_x14", 32'(vid_data), 32'd0);

    // Reset during WAIT aborts the access; the re-request sees normal latency
    advanceTo(100);
    applyStimulus(1'b1, 1'b0, 2'b00, 13'h0100, 16'd0);
    nextPix();
    nextPix();
    res_n = 1'b0;
    #2;
    checkAllZero("midrst");
    nextPix();
    checkOutput("midrst_ack_x103", 32'(bus.cpu_ack), 32'd0);
    res_n = 1'b1;
    nextPix();
    nextPix();
    checkOutput("rerq_ack_x105", 32'(bus.cpu_ack), 32'd0);
    nextPix();
    checkOutput("rerq_ack_x106", 32'(bus.cpu_ack), 32'd1);
    checkOutput("rerq_rdata_x106", 32'(bus.cpu_rdata), 32'h0100);
    applyStimulus(1'b0, 1'b0, 2'b00, 13'd0, 16'd0);

    // Scroll write mid-frame is invisible until the frame latch
    setPos(100, 300);
    scroll_we = 1'b1;
    scroll_in = 8'd250;
    nextPix();
    scroll_we = 1'b0;
    scroll_in = 8'd0;
    setPos(0, 20);
    advanceTo(12);
    checkOutput("scroll_before", 32'(bus.ram_addr), 32'h141);
    setPos(0, 0);
    nextPix();
    setPos(0, 20);
    advanceTo(12);
`ifdef VRAM_SCROLL_EN
    checkOutput("scroll_after", 32'(bus.ram_addr), 32'h081);
`else
    checkOutput("scroll_after", 32'(bus.ram_addr), 32'h141);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
